// File: rtl/multi_voice_signal_gen.sv
// Multi-voice phase-accumulator tone generator with a first-order delta-sigma 1-bit output.
// Optional noise voices are built only when SIGNAL_GEN_NOISE_EN is defined; otherwise wave 3 plays as square.
module multi_voice_signal_gen #(
   parameter int NUM_CH = 3,
   parameter int ACC_W  = 16,
   parameter int FREQ_W = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       write_strobe,
   input  logic [2:0] address,
   input  logic [4:0] data,
   output logic       signal_out,
   output logic [6:0] debug
);

   localparam int MIX_W = 8 + $clog2(NUM_CH);

   logic              s1, s2, s3;
   logic              write_pulse;
   logic [1:0]        ch_sel;
   logic [4:0]        stage_lo;
   logic              master_en;
   logic [FREQ_W-1:0] freq   [NUM_CH];
   logic [3:0]        vol    [NUM_CH];
   logic [1:0]        wave   [NUM_CH];
   logic [NUM_CH-1:0] ch_en;
   logic [ACC_W-1:0]  acc    [NUM_CH];
   logic [ACC_W-1:0]  acc_nxt[NUM_CH];
   logic [3:0]        samp   [NUM_CH];
   logic [7:0]        voice  [NUM_CH];
   logic [MIX_W-1:0]  mix_sum;
   logic [MIX_W-1:0]  mix;
   logic [MIX_W:0]    ds;
   logic              phase_clr;
`ifdef SIGNAL_GEN_NOISE_EN
   logic [14:0]       lfsr   [NUM_CH];
   logic [NUM_CH-1:0] carry;
`endif

   assign write_pulse = s2 & ~s3;
   assign phase_clr   = write_pulse && (address == 3'd5) && data[1];
   assign signal_out  = ds[MIX_W];
   assign debug       = mix[MIX_W-1 -: 7];

   always_comb begin
      mix_sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
`ifdef SIGNAL_GEN_NOISE_EN
         {carry[i], acc_nxt[i]} = {1'b0, acc[i]} + (ACC_W+1)'(freq[i]);
`else
         acc_nxt[i] = acc[i] + ACC_W'(freq[i]);
`endif
         case (wave[i])
            2'd1:    samp[i] = acc[i][ACC_W-1 -: 4];
            2'd2:    samp[i] = acc[i][ACC_W-1] ? ~acc[i][ACC_W-2 -: 4] : acc[i][ACC_W-2 -: 4];
`ifdef SIGNAL_GEN_NOISE_EN
            2'd3:    samp[i] = lfsr[i][3:0];
`endif
            default: samp[i] = {4{acc[i][ACC_W-1]}};
         endcase
         voice[i] = ch_en[i] ? 8'(samp[i]) * 8'(vol[i]) : 8'd0;
         mix_sum  = mix_sum + MIX_W'(voice[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         ch_sel    <= 2'd0;
         stage_lo  <= 5'd0;
         master_en <= 1'b0;
         ch_en     <= '0;
         mix       <= '0;
         ds        <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            freq[i] <= '0;
            vol[i]  <= 4'd0;
            wave[i] <= 2'd0;
            acc[i]  <= '0;
`ifdef SIGNAL_GEN_NOISE_EN
            lfsr[i] <= 15'h7FFF - 15'(i);
`endif
         end
      end else begin
         s1 <= write_strobe;
         s2 <= s1;
         s3 <= s2;

         if (write_pulse) begin
            case (address)
               3'd0: ch_sel    <= data[1:0];
               3'd1: stage_lo  <= data;
               3'd5: master_en <= data[0];
               default: ;
            endcase
         end

         for (int i = 0; i < NUM_CH; i++) begin
            // An out-of-range ch_sel matches no voice, so per-voice writes fall through.
            if (write_pulse && ch_sel == 2'(i)) begin
               case (address)
                  3'd2: freq[i] <= {data, stage_lo};
                  3'd3: begin
                     wave[i]  <= data[1:0];
                     ch_en[i] <= data[2];
                  end
                  3'd4: vol[i] <= data[3:0];
                  default: ;
               endcase
            end

            if (phase_clr) begin
               acc[i] <= '0;
            end else if (master_en && ch_en[i]) begin
               acc[i] <= acc_nxt[i];
`ifdef SIGNAL_GEN_NOISE_EN
               if (carry[i])
                  lfsr[i] <= {lfsr[i][13:0], lfsr[i][14] ^ lfsr[i][13]};
`endif
            end
         end

         if (master_en) begin
            mix <= mix_sum;
            ds  <= {1'b0, ds[MIX_W-1:0]} + {1'b0, mix};
         end else begin
            mix <= '0;
            ds  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_multi_voice_signal_gen.sv
// Directed bench for multi_voice_signal_gen (NUM_CH=3): register timing, pitch, mix, duty and phase reset.
module tb_multi_voice_signal_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       write_strobe;
   logic [2:0] address;
   logic [4:0] data;
   logic       signal_out;
   logic [6:0] debug;

   int total = 0;
   int bad   = 0;

   multi_voice_signal_gen dut (
      .clk          (clk),
      .rst          (rst),
      .write_strobe (write_strobe),
      .address      (address),
      .data         (data),
      .signal_out   (signal_out),
      .debug        (debug)
   );

   always #5 clk = ~clk;

   // Full-scale square on one voice: 15*15 = 225, debug = 225 >> 3 = 28.
   localparam logic [6:0] HI = 7'd28;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic write_reg(input logic [2:0] a, input logic [4:0] d);
      address      = a;
      data         = d;
      write_strobe = 1'b1;
      repeat (4) tick();
      write_strobe = 1'b0;
      repeat (3) tick();
   endtask

   task automatic wait_debug(input string tag, input logic [6:0] v, input int bound);
      int n = 0;
      while (debug !== v && n < bound) begin
         tick();
         n++;
      end
      chk(tag, int'(debug), int'(v));
   endtask

   task automatic run_len(input logic [6:0] v, output int n);
      n = 0;
      while (debug === v && n < 5000) begin
         n++;
         tick();
      end
   endtask

   int            len, ones, errs, changes;
   logic [6:0]    rec3 [300];
   logic [6:0]    rec0 [300];

   initial begin
      rst = 1'b1; write_strobe = 1'b0; address = 3'd0; data = 5'd0;
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_debug", int'(debug), 0);
      chk("reset_out", int'(signal_out), 0);
      errs = 0;
      repeat (100) begin
         tick();
         if (debug !== 7'd0 || signal_out !== 1'b0) errs++;
      end
      chk("idle_quiet", errs, 0);

      // ch0 square at freq 512, full volume
      write_reg(3'd0, 5'd0);
      write_reg(3'd1, 5'd0);
      write_reg(3'd2, 5'd16);
      write_reg(3'd3, 5'd4);
      write_reg(3'd4, 5'd15);
      write_reg(3'd5, 5'd1);
      wait_debug("first_high", HI, 300);
      run_len(HI, len);
      chk("square_high_len", len, 64);
      run_len(7'd0, len);
      chk("square_low_len", len, 64);

      // 2048 cycles = 16 periods, mix 225 for half of them -> 1024*225/1024 ones
      ones = 0;
      repeat (2048) begin
         tick();
         ones += int'(signal_out);
      end
      total++;
      assert (ones >= 224 && ones <= 226) else begin
         bad++;
         $error("FAIL duty observed=%0d expected=225+/-1", ones);
      end

      // Staging write alone must not retune
      write_reg(3'd1, 5'd31);
      wait_debug("lo_only_low", 7'd0, 200);
      wait_debug("lo_only_high", HI, 200);
      run_len(HI, len);
      chk("lo_only_pitch", len, 64);

      // freq = {0,16} = 16 -> half period 2048
      write_reg(3'd1, 5'd16);
      write_reg(3'd2, 5'd0);
      wait_debug("slow_low", 7'd0, 5000);
      wait_debug("slow_high", HI, 5000);
      run_len(HI, len);
      chk("slow_pitch", len, 2048);
      write_reg(3'd1, 5'd0);
      write_reg(3'd2, 5'd16);

      // VOL commit lands at edge k+2, mix follows one edge later
      wait_debug("vt_low", 7'd0, 200);
      wait_debug("vt_high", HI, 200);
      address = 3'd4; data = 5'd9; write_strobe = 1'b1;
      tick(); chk("vol_k", int'(debug), 28);
      tick(); chk("vol_k1", int'(debug), 28);
      tick(); chk("vol_k2", int'(debug), 28);
      tick(); chk("vol_k3", int'(debug), 16);
      tick();
      data = 5'd5;
      repeat (15) tick();
      chk("vol_held_once", int'(debug), 16);
      write_strobe = 1'b0;
      repeat (3) tick();
      write_reg(3'd4, 5'd15);

      // Out-of-range channel select: per-voice writes ignored
      write_reg(3'd0, 5'd3);
      write_reg(3'd4, 5'd9);
      write_reg(3'd3, 5'd0);
      write_reg(3'd0, 5'd0);
      wait_debug("sel_low", 7'd0, 200);
      wait_debug("sel_high", HI, 200);
      tick();
      chk("sel_ignored", int'(debug), 28);

      // Phase reset mid-tone
      repeat (5) tick();
      address = 3'd5; data = 5'd3; write_strobe = 1'b1;
      repeat (3) tick();
      chk("clr_k2", int'(debug), 28);
      tick();
      chk("clr_k3", int'(debug), 0);
      write_strobe = 1'b0;
      run_len(7'd0, len);
      chk("clr_low_len", len, 64);

      // Master off silences from the edge after commit
      address = 3'd5; data = 5'd0; write_strobe = 1'b1;
      repeat (4) tick();
      chk("moff_debug", int'(debug), 0);
      chk("moff_out", int'(signal_out), 0);
      write_strobe = 1'b0;
      errs = 0;
      repeat (50) begin
         tick();
         if (debug !== 7'd0 || signal_out !== 1'b0) errs++;
      end
      chk("moff_quiet", errs, 0);

      // ch1 wave 3 at freq 1023, ch0 disabled
      write_reg(3'd0, 5'd0);
      write_reg(3'd3, 5'd0);
      write_reg(3'd0, 5'd1);
      write_reg(3'd1, 5'd31);
      write_reg(3'd2, 5'd31);
      write_reg(3'd4, 5'd15);
      write_reg(3'd3, 5'd7);
      write_reg(3'd5, 5'd3);
      for (int i = 0; i < 300; i++) begin
         rec3[i] = debug;
         tick();
      end
      changes = 0;
      for (int i = 1; i < 300; i++) if (rec3[i] !== rec3[i-1]) changes++;
`ifdef SIGNAL_GEN_NOISE_EN
      // about 4 carries in this window: output moves only then
      total++;
      assert (changes >= 1 && changes <= 4) else begin
         bad++;
         $error("FAIL noise_changes observed=%0d expected=1..4", changes);
      end
`else
      total++;
      assert (changes >= 2) else begin
         bad++;
         $error("FAIL wave3_toggles observed=%0d expected>=2", changes);
      end
      write_reg(3'd3, 5'd4);
      write_reg(3'd5, 5'd3);
      for (int i = 0; i < 300; i++) begin
         rec0[i] = debug;
         tick();
      end
      errs = 0;
      for (int i = 0; i < 300; i++) if (rec0[i] !== rec3[i]) errs++;
      chk("wave3_is_square", errs, 0);
`endif

      // Reset during a pending MASTER write: write is dropped
      address = 3'd5; data = 5'd1; write_strobe = 1'b1;
      tick(); tick();
      rst = 1'b1; write_strobe = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("rst_mid_debug", int'(debug), 0);
      chk("rst_mid_out", int'(signal_out), 0);
      write_reg(3'd0, 5'd0);
      write_reg(3'd1, 5'd0);
      write_reg(3'd2, 5'd16);
      write_reg(3'd3, 5'd4);
      write_reg(3'd4, 5'd15);
      errs = 0;
      repeat (200) begin
         tick();
         if (debug !== 7'd0) errs++;
      end
      chk("pending_dropped", errs, 0);
      write_reg(3'd5, 5'd1);
      wait_debug("restart_high", HI, 300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
